// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_pkg
// Purpose  : Shared definitions for the data-bus responder. Contains the FSM
//            state type, the peripheral register addresses, the pattern
//            returned for unmapped reads, and a byte-strobe merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [31:0] LED_ADDR     = 32'hE000_0000;
  localparam logic [31:0] TIMER_ADDR   = 32'hE000_0004;
  localparam logic [31:0] SCRATCH_ADDR = 32'hE000_0008;
  localparam logic [31:0] DEAD_PATTERN = 32'hDEAD_BEEF;

  // Replace only the bytes of old_word whose strobe bit is set.
  function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage : dbus_pkg
`default_nettype wire

// File: rtl/dbus_ram.sv
`default_nettype none
// ============================================================================
// Module   : dbus_ram
// Purpose  : Single-clock word RAM with per-byte write enables and a
//            registered read port. Contents are not affected by reset.
// Ports    : clock       - rising-edge clock
//            byte_en     - per-byte write enables (all zero = no write)
//            write_index - word index written
//            write_data  - write data
//            read_index  - word index read (result appears next cycle)
//            read_data   - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module dbus_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic [3:0]    byte_en,
  input  logic [AW-1:0] write_index,
  input  logic [31:0]   write_data,
  input  logic [AW-1:0] read_index,
  output logic [31:0]   read_data
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) mem[write_index][8*b +: 8] <= write_data[8*b +: 8];
    end
    read_data <= mem[read_index];
  end

endmodule : dbus_ram
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder
// Purpose  : CPU data-bus slave. Accepts one-cycle request strobes, inserts
//            WAIT_CYCLES wait states, then pulses cpu_ack for one cycle.
//            Decodes an on-chip RAM, a 10-bit LED register, a scratch
//            register and (optionally) a free-running timer. Any other
//            address completes with 0xDEAD_BEEF and sets sticky bus_error.
// Config   : define DBUS_TIMER_EN to include the read-only timer at
//            0xE000_0004; otherwise that address is unmapped.
// Ports    : clock, reset          - clock / async active-high reset
//            cpu_request           - transaction strobe
//            cpu_address/write/wstrb/wdata - transaction attributes
//            cpu_rdata, cpu_ack    - read data and completion pulse
//            led                   - LED register
//            bus_error             - sticky unmapped-access flag
// Revision : 1.0 - initial release
// ============================================================================
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int RAM_WORDS   = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  input  logic [31:0] cpu_address,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic [9:0]  led,
  output logic        bus_error
);

  localparam int         AW        = $clog2(RAM_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic [29:0] req_word;
  logic        req_write;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [9:0]  led_reg;
  logic [31:0] scratch;
  logic        bus_err_reg;

  logic [31:0] byte_addr;
  logic        hit_ram, hit_led, hit_scratch, hit_timer, mapped, commit;
  logic [31:0] ram_rdata, read_value;
  logic [AW-1:0] ram_read_index;

  // Byte-lane selects within a word are never used for decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_address[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cpu_request) state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (wait_cnt == WAIT_LAST) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter holds 1 in the first wait cycle so WAIT lasts exactly WAIT_CYCLES.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     wait_cnt <= 4'd0;
    else if (state_next != ST_WAIT) wait_cnt <= 4'd0;
    else if (state == ST_WAIT)     wait_cnt <= wait_cnt + 4'd1;
    else                           wait_cnt <= 4'd1;
  end

  // Transaction attributes are captured only when a request is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_word  <= '0;
      req_write <= 1'b0;
      req_wstrb <= '0;
      req_wdata <= '0;
    end else if (state == ST_IDLE && cpu_request) begin
      req_word  <= cpu_address[31:2];
      req_write <= cpu_write;
      req_wstrb <= cpu_wstrb;
      req_wdata <= cpu_wdata;
    end
  end

  // ------------------------------------------------------------- decode
  assign byte_addr   = {req_word, 2'b00};
  assign hit_ram     = (byte_addr >> (AW + 2)) == 32'd0;
  assign hit_led     = byte_addr == LED_ADDR;
  assign hit_scratch = byte_addr == SCRATCH_ADDR;
`ifdef DBUS_TIMER_EN
  assign hit_timer   = byte_addr == TIMER_ADDR;
`else
  assign hit_timer   = 1'b0;
`endif
  assign mapped      = hit_ram | hit_led | hit_scratch | hit_timer;
  assign commit      = (state == ST_ACK) && req_write;

  // While idle the RAM is addressed straight from the bus so that the
  // registered read is ready even when there are no wait states.
  assign ram_read_index = (state == ST_IDLE) ? cpu_address[AW+1:2] : req_word[AW-1:0];

  dbus_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clock       (clock),
    .byte_en     ((commit && hit_ram) ? req_wstrb : 4'b0000),
    .write_index (req_word[AW-1:0]),
    .write_data  (req_wdata),
    .read_index  (ram_read_index),
    .read_data   (ram_rdata)
  );

  // ---------------------------------------------------------- registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_reg     <= '0;
      scratch     <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      if (commit && hit_led) begin
        if (req_wstrb[0]) led_reg[7:0] <= req_wdata[7:0];
        if (req_wstrb[1]) led_reg[9:8] <= req_wdata[9:8];
      end
      if (commit && hit_scratch) scratch <= apply_strobe(scratch, req_wdata, req_wstrb);
      if (state == ST_ACK && !mapped) bus_err_reg <= 1'b1;
    end
  end

`ifdef DBUS_TIMER_EN
  logic [31:0] timer;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) timer <= '0;
    else       timer <= timer + 32'd1;
  end
`endif

  // ------------------------------------------------------------ outputs
  always_comb begin
    read_value = DEAD_PATTERN;
    if (hit_ram)          read_value = ram_rdata;
    else if (hit_led)     read_value = {22'b0, led_reg};
    else if (hit_scratch) read_value = scratch;
`ifdef DBUS_TIMER_EN
    else if (hit_timer)   read_value = timer;
`endif
  end

  assign cpu_ack   = (state == ST_ACK);
  assign cpu_rdata = (cpu_ack && !req_write) ? read_value : 32'd0;
  assign led       = led_reg;
  assign bus_error = bus_err_reg;

endmodule : dbus_responder
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_responder
// Purpose  : Self-checking bench for dbus_responder. A reference model of the
//            address map (RAM words, LED, scratch, sticky error) predicts
//            every read value and register state; transactions are directed
//            plus a randomized mix over RAM, LED and scratch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_responder;

  localparam int          RAM_WORDS   = 4096;
  localparam int          WAIT_CYCLES = 1;
  localparam int          LATENCY     = 1 + WAIT_CYCLES;
  localparam logic [31:0] DEAD        = 32'hDEAD_BEEF;
  localparam logic [31:0] A_LED       = 32'hE000_0000;
  localparam logic [31:0] A_TIMER     = 32'hE000_0004;
  localparam logic [31:0] A_SCRATCH   = 32'hE000_0008;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_request;
  logic [31:0] cpu_address;
  logic        cpu_write;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic [9:0]  led;
  logic        bus_error;

  always #5 clock = ~clock;

  dbus_responder #(.RAM_WORDS(RAM_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_request (cpu_request),
    .cpu_address (cpu_address),
    .cpu_write   (cpu_write),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .led         (led),
    .bus_error   (bus_error)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of the address map.
  logic [31:0] ram_m [int];
  logic [9:0]  led_m;
  logic [31:0] scratch_m;
  logic        err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (a < 32'(4 * RAM_WORDS)) return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'hX;
    if (a == A_LED)             return {22'b0, led_m};
    if (a == A_SCRATCH)         return scratch_m;
    return DEAD;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] a;
    logic [31:0] led_w;
    a = {addr[31:2], 2'b00};
    if (a < 32'(4 * RAM_WORDS)) begin
      ram_m[int'(a >> 2)] = merge(ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0, wd, strb);
    end else if (a == A_LED) begin
      led_w = {22'b0, led_m};
      if (strb[0]) led_w[7:0] = wd[7:0];
      if (strb[1]) led_w[9:8] = wd[9:8];
      led_m = led_w[9:0];
    end else if (a == A_SCRATCH) begin
      scratch_m = merge(scratch_m, wd, strb);
    end else if (a != A_TIMER) begin
      err_m = 1'b1;
    end else begin
`ifndef DBUS_TIMER_EN
      err_m = 1'b1;
`endif
    end
  endtask

  // One complete transaction: request for one cycle, scramble the bus while
  // waiting, measure ack latency, check the ack is a single pulse.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wd,
                     output logic [31:0] rd);
    int lat;
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = wr; cpu_address = addr; cpu_wstrb = strb; cpu_wdata = wd;
    @(negedge clock);
    cpu_request = 1'b0;
    cpu_address = $urandom; cpu_wdata = $urandom;
    cpu_write = 1'($urandom_range(0, 1)); cpu_wstrb = 4'($urandom_range(0, 15));
    lat = 1;
    while (!cpu_ack && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = cpu_rdata;
    check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    if (wr) check({tag, "_wr_rdata"}, rd, 32'h0);
    @(negedge clock);
    check({tag, "_ack_pulse"}, 32'(cpu_ack), 32'h0);
    check({tag, "_idle_rdata"}, cpu_rdata, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr, wd, t1, t2;
    logic [3:0]  strb;
    logic        wr;
    int          acks, kind;

    reset = 1'b1; cpu_request = 1'b0; cpu_address = '0; cpu_write = 1'b0;
    cpu_wstrb = '0; cpu_wdata = '0;
    led_m = '0; scratch_m = '0; err_m = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ack", 32'(cpu_ack), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    reset = 1'b0;

    // Full-word write then read-back
    txn("ram_wr", 1'b1, 32'h10, 4'hF, 32'h1234_5678, rd); model_write(32'h10, 4'hF, 32'h1234_5678);
    txn("ram_rd", 1'b0, 32'h10, 4'h0, 32'h0, rd);
    check("ram_rd_data", rd, 32'h1234_5678);

    // Single-byte strobe over existing data
    txn("ram_wr_b1", 1'b1, 32'h10, 4'h2, 32'hAABB_CCDD, rd); model_write(32'h10, 4'h2, 32'hAABB_CCDD);
    txn("ram_rd_b1", 1'b0, 32'h10, 4'h0, 32'h0, rd);
    check("ram_rd_b1_data", rd, 32'h1234_CC78);

    // Zero strobe writes nothing but still completes
    txn("ram_wr_s0", 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, rd);
    txn("ram_rd_s0", 1'b0, 32'h10, 4'h0, 32'h0, rd);
    check("ram_rd_s0_data", rd, model_read(32'h10));

    // LED register
    txn("led_wr", 1'b1, A_LED, 4'h3, 32'hFFFF_FFFF, rd); model_write(A_LED, 4'h3, 32'hFFFF_FFFF);
    check("led_out", 32'(led), 32'(led_m));
    txn("led_wr_lo", 1'b1, A_LED, 4'h1, 32'h0, rd); model_write(A_LED, 4'h1, 32'h0);
    check("led_out_lo", 32'(led), 32'h300);
    txn("led_rd", 1'b0, A_LED, 4'h0, 32'h0, rd);
    check("led_rd_data", rd, model_read(A_LED));

    // Initialise a RAM window with full words, then random mixed traffic
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      txn("init", 1'b1, 32'h100 + 32'(4 * i), 4'hF, wd, rd);
      model_write(32'h100 + 32'(4 * i), 4'hF, wd);
    end
    for (int i = 0; i < 48; i++) begin
      kind = int'($urandom_range(0, 9));
      wr   = 1'($urandom_range(0, 1));
      strb = 4'($urandom_range(0, 15));
      wd   = $urandom;
      if (kind < 6)      addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
      else if (kind < 8) addr = A_SCRATCH;
      else               addr = A_LED;
      addr = addr | 32'($urandom_range(0, 3));
      txn("rand", wr, addr, strb, wd, rd);
      if (wr) model_write(addr, strb, wd);
      else    check("rand_rd_data", rd, model_read(addr));
      check("rand_led", 32'(led), 32'(led_m));
      check("rand_bus_error", 32'(bus_error), 32'(err_m));
    end

    // Timer (optional)
`ifdef DBUS_TIMER_EN
    txn("tmr_wr", 1'b1, A_TIMER, 4'hF, 32'h0, rd);
    check("tmr_wr_no_err", 32'(bus_error), 32'h0);
    txn("tmr_rd1", 1'b0, A_TIMER, 4'h0, 32'h0, t1);
    repeat (6) @(negedge clock);
    txn("tmr_rd2", 1'b0, A_TIMER, 4'h0, 32'h0, t2);
    check("tmr_delta", t2 - t1, 32'd10);
`else
    txn("tmr_rd1", 1'b0, A_TIMER, 4'h0, 32'h0, t1);
    err_m = 1'b1;
    check("tmr_unmapped", t1, DEAD);
    check("tmr_bus_error", 32'(bus_error), 32'h1);
    t2 = t1;
`endif

    // Unmapped accesses; error flag is sticky
    txn("unm_rd", 1'b0, 32'h8000_0000, 4'h0, 32'h0, rd); err_m = 1'b1;
    check("unm_rd_data", rd, DEAD);
    check("unm_bus_error", 32'(bus_error), 32'h1);
    txn("unm_wr", 1'b1, 32'hE000_000C, 4'hF, 32'h5555_5555, rd);
    repeat (5) @(negedge clock);
    check("unm_sticky", 32'(bus_error), 32'h1);
    txn("scr_after_unm", 1'b0, A_SCRATCH, 4'h0, 32'h0, rd);
    check("scr_after_unm_data", rd, scratch_m);

    // Requests during WAIT and ACK are ignored
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 32'h10;
    acks = 0;
    @(negedge clock);
    acks += int'(cpu_ack);
    cpu_request = 1'b1; cpu_address = 32'h104;
    @(negedge clock);
    acks += int'(cpu_ack);
    check("dup_rd_data", cpu_rdata, model_read(32'h10));
    cpu_request = 1'b1;
    repeat (7) begin
      @(negedge clock);
      cpu_request = 1'b0;
      acks += int'(cpu_ack);
    end
    check("dup_ack_count", 32'(acks), 32'd1);

    // Reset mid-WAIT on an LED write
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = 1'b1; cpu_address = A_LED; cpu_wstrb = 4'h3; cpu_wdata = 32'h3FF;
    @(negedge clock);
    cpu_request = 1'b0;
    reset = 1'b1;
    acks = 0;
    repeat (3) begin
      @(negedge clock);
      acks += int'(cpu_ack);
    end
    reset = 1'b0;
    led_m = '0; scratch_m = '0; err_m = 1'b0;
    repeat (3) begin
      @(negedge clock);
      acks += int'(cpu_ack);
    end
    check("rst_mid_acks", 32'(acks), 32'd0);
    check("rst_mid_led", 32'(led), 32'h0);
    check("rst_mid_bus_error", 32'(bus_error), 32'h0);
    txn("post_rst_ram", 1'b0, 32'h10, 4'h0, 32'h0, rd);
    check("post_rst_ram_data", rd, model_read(32'h10));
    txn("post_rst_scr", 1'b0, A_SCRATCH, 4'h0, 32'h0, rd);
    check("post_rst_scr_data", rd, 32'h0);
    txn("post_rst_led", 1'b0, A_LED, 4'h0, 32'h0, rd);
    check("post_rst_led_data", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dbus_responder
`default_nettype wire
